// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with byte lanes and scrub.
// Ports: clk/clear, address, RAM_data_in, byte_en, write/read_enable -> RAM_data_out, rd_valid, busy.
module ram_sync_param #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 9,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    RW_MODE        = 0,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter                        INIT_FILE      = "",
  parameter logic [DATA_WIDTH-1:0] INIT_DATA_OUT  = '0
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   RAM_data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic                    write_enable,
  input  logic                    read_enable,
  output logic [DATA_WIDTH-1:0]   RAM_data_out,
  output logic                    rd_valid,
  output logic                    busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_SCRUB,
    ST_IDLE
  } state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] scrub_ptr_q, scrub_ptr_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_vld_q, s1_vld_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  vld_q, vld_d;

  logic                  idle;
  logic                  wr_go;
  logic                  rd_go;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    idle     = (state_q == ST_IDLE);
    wr_go    = idle && write_enable;
    rd_go    = idle && read_enable;
    old_word = mem[address];
    merged   = old_word;
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = RAM_data_in[8*i +: 8];
    end
    rd_word = (RW_MODE == 1 && wr_go) ? merged : old_word;
  end

  always_comb begin
    state_d     = state_q;
    scrub_ptr_d = scrub_ptr_q;
    if (state_q == ST_SCRUB) begin
      scrub_ptr_d = scrub_ptr_q + 1'b1;
      if (scrub_ptr_q == '1) state_d = ST_IDLE;
    end
  end

  always_comb begin
    s1_vld_d  = rd_go;
    s1_data_d = rd_go ? rd_word : s1_data_q;
    if (READ_LATENCY == 2) begin
      vld_d  = s1_vld_q;
      dout_d = s1_vld_q ? s1_data_q : dout_q;
    end else begin
      vld_d  = rd_go;
      dout_d = rd_go ? rd_word : dout_q;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_SCRUB : ST_IDLE;
      scrub_ptr_q <= '0;
      s1_data_q   <= '0;
      s1_vld_q    <= 1'b0;
      dout_q      <= INIT_DATA_OUT;
      vld_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      scrub_ptr_q <= scrub_ptr_d;
      s1_data_q   <= s1_data_d;
      s1_vld_q    <= s1_vld_d;
      dout_q      <= dout_d;
      vld_q       <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      if (state_q == ST_SCRUB) begin
        mem[scrub_ptr_q] <= '0;
      end else if (wr_go) begin
        for (int i = 0; i < NB; i++) begin
          if (byte_en[i]) mem[address][8*i +: 8] <= RAM_data_in[8*i +: 8];
        end
      end
    end
  end

  assign RAM_data_out = dout_q;
  assign rd_valid     = vld_q;
  assign busy         = (state_q == ST_SCRUB);

endmodule

// File: tb/tb_ram_sync_param.sv
// Directed bench for ram_sync_param: instance a (LAT=1, read-first),
// instance b (LAT=2, write-first, nonzero reset output).
module tb_ram_sync_param;

  logic        clk = 1'b0;
  logic        clear;
  logic [8:0]  address;
  logic [31:0] din;
  logic [3:0]  byte_en;
  logic        we;
  logic        re;

  logic [31:0] dout_a, dout_b;
  logic        vld_a, vld_b;
  logic        busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_sync_param u_a (
    .clk(clk), .clear(clear), .address(address),
    .RAM_data_in(din), .byte_en(byte_en),
    .write_enable(we), .read_enable(re),
    .RAM_data_out(dout_a), .rd_valid(vld_a), .busy(busy_a)
  );

  ram_sync_param #(
    .READ_LATENCY(2), .RW_MODE(1),
    .INIT_DATA_OUT(32'hCAFE0000)
  ) u_b (
    .clk(clk), .clear(clear), .address(address),
    .RAM_data_in(din), .byte_en(byte_en),
    .write_enable(we), .read_enable(re),
    .RAM_data_out(dout_b), .rd_valid(vld_b), .busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    address = a; din = d; byte_en = be; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [8:0] a,
                    input logic [31:0] ea, input logic [31:0] eb);
    address = a; re = 1'b1;
    step();
    re = 1'b0;
    chk({tag, "_a_vld"}, 32'(vld_a), 32'd1);
    chk({tag, "_a_dat"}, dout_a, ea);
    chk({tag, "_b_early"}, 32'(vld_b), 32'd0);
    step();
    chk({tag, "_b_vld"}, 32'(vld_b), 32'd1);
    chk({tag, "_b_dat"}, dout_b, eb);
    chk({tag, "_a_hold"}, dout_a, ea);
    chk({tag, "_a_pulse"}, 32'(vld_a), 32'd0);
  endtask

  task automatic busy_run(input string tag);
    int n;
    bit stray;
    n = 0;
    stray = 0;
    do begin
      step();
      n++;
      if (vld_a || vld_b) stray = 1;
      we = 1'b0;
      re = 1'b0;
    end while (busy_a && n < 600);
    chk({tag, "_cycles"}, 32'(n), 32'd512);
    chk({tag, "_b_idle"}, 32'(busy_b), 32'd0);
    chk({tag, "_no_vld"}, 32'(stray), 32'd0);
  endtask

  initial begin
    clear = 1'b1; address = '0; din = '0;
    byte_en = '0; we = 1'b0; re = 1'b0;
    step();
    chk("rst_busy_a", 32'(busy_a), 32'd1);
    chk("rst_busy_b", 32'(busy_b), 32'd1);
    chk("rst_vld_a", 32'(vld_a), 32'd0);
    chk("rst_vld_b", 32'(vld_b), 32'd0);
    chk("rst_dout_a", dout_a, 32'h0);
    chk("rst_dout_b", dout_b, 32'hCAFE0000);

    clear = 1'b0;
    address = 9'h005; din = 32'hAA; byte_en = 4'hF;
    we = 1'b1; re = 1'b1;
    busy_run("scrub");

    rd("rd000", 9'h000, 32'h0, 32'h0);
    rd("rd1ff", 9'h1FF, 32'h0, 32'h0);
    rd("drop05", 9'h005, 32'h0, 32'h0);

    wr(9'h054, 32'hDEADBEEF, 4'hF);
    rd("lat54", 9'h054, 32'hDEADBEEF, 32'hDEADBEEF);

    wr(9'h092, 32'hFFFFFFFF, 4'hF);
    wr(9'h092, 32'h12345678, 4'b0101);
    rd("lanes", 9'h092, 32'hFF34FF78, 32'hFF34FF78);
    wr(9'h092, 32'h00000000, 4'b0000);
    rd("be0", 9'h092, 32'hFF34FF78, 32'hFF34FF78);

    wr(9'h010, 32'h11111111, 4'hF);
    address = 9'h010; din = 32'h22222222; byte_en = 4'hF;
    we = 1'b1; re = 1'b1;
    step();
    we = 1'b0; re = 1'b0;
    chk("col_a", dout_a, 32'h11111111);
    step();
    chk("col_b", dout_b, 32'h22222222);
    rd("col_after", 9'h010, 32'h22222222, 32'h22222222);

    address = 9'h010; din = 32'h33333333; byte_en = 4'b0011;
    we = 1'b1; re = 1'b1;
    step();
    we = 1'b0; re = 1'b0;
    chk("colp_a", dout_a, 32'h22222222);
    step();
    chk("colp_b", dout_b, 32'h22223333);

    re = 1'b1; address = 9'h054;
    step();
    chk("b2b_a0", dout_a, 32'hDEADBEEF);
    address = 9'h092;
    step();
    re = 1'b0;
    chk("b2b_a1", dout_a, 32'hFF34FF78);
    chk("b2b_a1v", 32'(vld_a), 32'd1);
    chk("b2b_b0", dout_b, 32'hDEADBEEF);
    chk("b2b_b0v", 32'(vld_b), 32'd1);
    step();
    chk("b2b_b1", dout_b, 32'hFF34FF78);
    chk("b2b_b1v", 32'(vld_b), 32'd1);
    chk("b2b_aend", 32'(vld_a), 32'd0);

    address = 9'h054; re = 1'b1;
    step();
    chk("fl_a_vld", 32'(vld_a), 32'd1);
    re = 1'b0; clear = 1'b1;
    step();
    chk("fl_b_vld", 32'(vld_b), 32'd0);
    chk("fl_b_dat", dout_b, 32'hCAFE0000);
    chk("fl_a_dat", dout_a, 32'h0);
    chk("fl_busy", 32'(busy_a), 32'd1);

    clear = 1'b0;
    repeat (100) step();
    chk("mid_busy", 32'(busy_a), 32'd1);
    clear = 1'b1; re = 1'b1; address = 9'h054;
    step();
    clear = 1'b0; re = 1'b0;
    chk("mid_vld_a", 32'(vld_a), 32'd0);
    chk("mid_vld_b", 32'(vld_b), 32'd0);
    busy_run("rescrub");
    rd("post54", 9'h054, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
